// File: rtl/ccip_rd_reorder_buffer.sv
// Reorder buffer for out-of-order CCI-P read responses: allocates slot tags for
// outgoing reads, captures responses by slot, and drains lines in request order.
module ccip_rd_reorder_buffer #(
  parameter int TAG_WIDTH  = 4,
  parameter int DATA_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [1:0]            req_len,
  output logic                  req_ready,
  output logic [TAG_WIDTH-1:0]  req_tag,
  input  logic                  rsp_valid,
  input  logic [TAG_WIDTH-1:0]  rsp_tag,
  input  logic [1:0]            rsp_cl_num,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH:0]    occupancy,
  output logic                  err_len,
  output logic                  err_rsp
);

  localparam int DEPTH = 1 << TAG_WIDTH;

  logic [DEPTH-1:0]      alloc_q, alloc_d;
  logic [DEPTH-1:0]      filled_q, filled_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [TAG_WIDTH-1:0]  tail_q, head_q, rsp_slot;
  logic [TAG_WIDTH:0]    occ_q;
  logic [TAG_WIDTH+1:0]  free_slots;
  logic [2:0]            req_n;
  logic                  accept, rsp_ok, load;

  assign req_n      = (req_len == 2'b11) ? 3'd4 : ({1'b0, req_len} + 3'd1);
  assign free_slots = (TAG_WIDTH+2)'(DEPTH) - {1'b0, occ_q};
  assign req_ready  = (req_len != 2'b10) && (free_slots >= (TAG_WIDTH+2)'(req_n));
  assign req_tag    = tail_q;
  assign occupancy  = occ_q;
  assign accept     = req_valid && req_ready;

  // Multi-line responses share the base tag; cl_num selects the line slot.
  assign rsp_slot = rsp_tag + TAG_WIDTH'(rsp_cl_num);
  assign rsp_ok   = rsp_valid && alloc_q[rsp_slot] && !filled_q[rsp_slot];
  assign load     = alloc_q[head_q] && filled_q[head_q] && (!out_valid || out_ready);

  always_comb begin
    alloc_d  = alloc_q;
    filled_d = filled_q;
    if (load) begin
      alloc_d[head_q]  = 1'b0;
      filled_d[head_q] = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (accept && (3'(i) < req_n)) begin
        alloc_d[tail_q + TAG_WIDTH'(i)] = 1'b1;
      end
    end
    if (rsp_ok) begin
      filled_d[rsp_slot] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_q   <= '0;
      filled_q  <= '0;
      tail_q    <= '0;
      head_q    <= '0;
      occ_q     <= '0;
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_data  <= '0;
      err_len   <= 1'b0;
      err_rsp   <= 1'b0;
    end else begin
      alloc_q  <= alloc_d;
      filled_q <= filled_d;
      if (accept) begin
        tail_q <= tail_q + TAG_WIDTH'(req_n);
      end
      occ_q <= occ_q + (accept ? (TAG_WIDTH+1)'(req_n) : '0) - (TAG_WIDTH+1)'(load);
      if (load) begin
        out_valid <= 1'b1;
        out_tag   <= head_q;
        out_data  <= mem[head_q];
        head_q    <= head_q + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      err_len <= req_valid && (req_len == 2'b10);
      err_rsp <= rsp_valid && !rsp_ok;
    end
  end

  // Line storage needs no reset: a slot is only read once its filled bit is set.
  always_ff @(posedge clk) begin
    if (rsp_ok) begin
      mem[rsp_slot] <= rsp_data;
    end
  end

endmodule

// File: doc/ccip_rd_reorder_buffer.md
# ccip_rd_reorder_buffer

AFU-side receiver for the out-of-order CCI-P read response channel. It allocates response slots for outgoing read requests and hands the caller the slot tag to place in `mdata`. It captures read responses as they return in any order and drains them strictly in request order. It sits between the AFU request logic and the RX response path, and restores ordering that the channel model deliberately scrambles.

## Interface
Parameters:
- `TAG_WIDTH`, 4: slot index width; `DEPTH = 2**TAG_WIDTH` slots (16).
- `DATA_WIDTH`, 512: cache-line width; equals `CCIP_DATA_WIDTH`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  AFU offers a read request this cycle.
- `req_len`  in  2  CCI-P line count: 2'b00=1, 2'b01=2, 2'b11=4; 2'b10 is illegal.
- `req_ready`  out  1  enough free slots for `req_len`; a request is accepted when `req_valid && req_ready`.
- `req_tag`  out  TAG_WIDTH  base slot for the request, driven combinationally from the tail pointer; the caller places it in `mdata[TAG_WIDTH-1:0]`.
- `rsp_valid`  in  1  read response line present.
- `rsp_tag`  in  TAG_WIDTH  `mdata[TAG_WIDTH-1:0]` echoed from the request.
- `rsp_cl_num`  in  2  line offset within a multi-line request.
- `rsp_data`  in  DATA_WIDTH  response line.
- `out_valid`  out  1  in-order line available.
- `out_ready`  in  1  consumer accepts the line.
- `out_tag`  out  TAG_WIDTH  slot index of the emitted line.
- `out_data`  out  DATA_WIDTH  emitted line.
- `occupancy`  out  TAG_WIDTH+1  slots allocated and not yet drained into the output register.
- `err_len`  out  1  one-cycle pulse: `req_valid` with `req_len == 2'b10`.
- `err_rsp`  out  1  one-cycle pulse: a response hit an unallocated or already-filled slot; that response is dropped.

## Operation
- State:
  - Per-slot `alloc` and `filled` bits.
  - Data array of `DEPTH x DATA_WIDTH`.
  - `tail` (allocation) pointer and `head` (drain) pointer, both `TAG_WIDTH` bits wide and wrapping modulo `DEPTH`.
  - `occupancy` counter.
- Line count `n = {req_len == 2'b11 ? 4 : req_len + 1}`.
- Allocation:
  - `req_ready = (req_len != 2'b10) && (DEPTH - occupancy >= n)`.
  - On accept, set `alloc` for slots `tail .. tail+n-1` (mod DEPTH) and advance `tail` by `n`.
  - Slots wrap; a 4-line request at `tail = 14` uses slots 14, 15, 0, 1.
- Response capture:
  - Slot index is `s = rsp_tag + rsp_cl_num` (mod DEPTH).
  - If `alloc[s] && !filled[s]`, write `rsp_data` and set `filled[s]`.
  - Otherwise pulse `err_rsp` and leave the slot unchanged.
- Drain:
  - The output register loads from `head` when `alloc[head] && filled[head]` and (`!out_valid || out_ready`).
  - On load, clear `alloc[head]` and `filled[head]`, then advance `head`.
  - If `out_valid && out_ready` and nothing loads, `out_valid` drops.
- Occupancy: `occupancy_next = occupancy + (accept ? n : 0) - (load ? 1 : 0)`. Simultaneous allocate and drain are both applied in the same cycle.
- Response into the head slot on the same cycle as a drain attempt: the drain decision uses registered `filled`, so that line drains on the next cycle.
- Reset:
  - Clears all `alloc` and `filled` bits, both pointers, and `occupancy`.
  - `out_valid`, `err_len` and `err_rsp` go to 0; `out_tag` and `out_data` go to 0.
  - Responses arriving after a mid-operation reset target unallocated slots and pulse `err_rsp`.

## Timing
- `req_tag` and `req_ready` are combinational from registered state and `req_len`. There is no request-to-ready path through `req_valid`.
- Allocation takes effect at the accepting edge. A response may arrive the cycle after the request is accepted.
- A response captured at edge k drives `out_valid` high after edge k+1, if it is the head slot and the output register is free. Minimum response-to-output latency is 2 edges.
- Full throughput: with `out_ready` held high and responses in order, one line is emitted per cycle.
- `err_len` and `err_rsp` are registered and assert for exactly one cycle, the cycle after the offending input.
- `out_data` and `out_tag` are held stable while `out_valid && !out_ready`.

## Test plan
- Reset, then issue 16 single-line requests, then return responses in reverse order (tags 15..0). Required: tags 0..15 are assigned, `req_ready` = 0 at `occupancy` = 16, and nothing is emitted until tag 0 arrives. Then 16 lines are emitted in order 0..15, each with `out_data` matching its tag.
- Issue a 4-line request at `tail = 14`, then return `cl_num` 3, 1, 0, 2. Required: output tags 14, 15, 0, 1 in order, and `occupancy` returns to 0.
- Respond twice to tag 3, and also respond to unallocated tag 9. Required: one `err_rsp` pulse for each bad response, and the original tag-3 data is emitted unchanged.
- Drive `req_valid` with `req_len = 2'b10`. Required: `req_ready` = 0, one `err_len` pulse, and `tail` is unchanged.
- Toggle `out_ready` randomly (50%) while responses return. Required: no line is lost or duplicated, output order holds, and data is stable while stalled.
- Assert `rst_n` low with 8 slots outstanding, then deliver 2 late responses after reset. Required: all outputs are 0, `occupancy` = 0, and 2 `err_rsp` pulses occur.
